dbus_dma: RTL and testbench

Bus-master copy engine for the data bus. On a start pulse it requests the bus, reads `len` words from a source address and writes them to a destination address, then pulses `done`. It sits beside the core as a second initiator on the data bus; an external arbiter owns `bus_gnt`. It moves blocks between RAM and the GPIO window without core involvement.

---
 rtl/dbus_pkg.sv | 20 ++
 rtl/dbus_dma_if.sv | 24 ++
 rtl/dbus_dma.sv | 81 ++++++++
 tb/tb_dbus_dma.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared data-bus definitions: default widths, DMA state encoding and address map.
package dbus_pkg;

  localparam int unsigned DBUS_DW        = 16;
  localparam int unsigned DBUS_AW        = 16;
  localparam int unsigned DBUS_MEM_DEPTH = 8192;

  localparam logic [15:0] GPIO_IN_ADDR  = 16'h2000;
  localparam logic [15:0] GPIO_OUT_ADDR = 16'h2001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } dma_state_t;

endpackage

// File: rtl/dbus_dma_if.sv
// Data-bus initiator port: arbiter handshake plus single-cycle address/data bus.
interface dbus_dma_if
  import dbus_pkg::*;
#(
  parameter int unsigned DW = DBUS_DW,
  parameter int unsigned AW = DBUS_AW
);
  logic          bus_req;
  logic          bus_gnt;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_we;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req, bus_addr, bus_wdata, bus_we,
    input  bus_gnt, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr, bus_wdata, bus_we,
    output bus_gnt, bus_rdata
  );
endinterface

// File: rtl/dbus_dma.sv
// Bus-master block copy engine: read-wait-write per word, ascending addresses.
module dbus_dma
  import dbus_pkg::*;
#(
  parameter int unsigned DW = DBUS_DW,
  parameter int unsigned AW = DBUS_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  dbus_dma_if.master    bus
);

  dma_state_t    state, state_nxt;
  logic [AW-1:0] src_r, dst_r, len_r, cnt;
  logic [DW-1:0] data_buf;
  logic [AW-1:0] last_idx;

  assign last_idx = len_r - AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_r    <= '0;
      dst_r    <= '0;
      len_r    <= '0;
      cnt      <= '0;
      data_buf <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        src_r <= src;
        dst_r <= dst;
        len_r <= len;
        cnt   <= '0;
      end
      // Read data arrives exactly one cycle after the RD address cycle.
      if (state == S_WAIT) data_buf <= bus.bus_rdata;
      if (state == S_WR && cnt != last_idx) cnt <= cnt + AW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len == '0) ? S_DONE : S_REQ;
      S_REQ:  if (bus.bus_gnt) state_nxt = S_RD;
      S_RD:   state_nxt = S_WAIT;
      S_WAIT: state_nxt = S_WR;
      S_WR:   state_nxt = (cnt == last_idx) ? S_DONE : S_RD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    bus.bus_req   = (state == S_REQ) || (state == S_RD) || (state == S_WAIT) || (state == S_WR);
    bus.bus_we    = (state == S_WR);
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    case (state)
      S_RD: bus.bus_addr = src_r + cnt;
      S_WR: begin
        bus.bus_addr  = dst_r + cnt;
        bus.bus_wdata = data_buf;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbus_dma.sv
// Bench for dbus_dma: full-range bus memory with GPIO window, transaction-level model.
module tb_dbus_dma;
  import dbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic        busy, done;
  logic        gnt_drv = 1'b1;

  dbus_dma_if #(.DW(16), .AW(16)) bif ();
  assign bif.bus_gnt = gnt_drv;

  dbus_dma #(.DW(16), .AW(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Bus slave: one-cycle read latency, GPIO window mapped into the address space.
  logic [15:0] mem    [0:65535];
  logic [15:0] refmem [0:65535];
  logic [15:0] gpio_in = '0, gpio_out = '0, ref_gpio_out = '0;
  int          we_count = 0;

  always @(posedge clk) begin
    if (bif.bus_we) begin
      we_count++;
      if (bif.bus_addr == GPIO_OUT_ADDR) gpio_out <= bif.bus_wdata;
      else                               mem[bif.bus_addr] <= bif.bus_wdata;
    end
    bif.bus_rdata <= (bif.bus_addr == GPIO_IN_ADDR) ? gpio_in : mem[bif.bus_addr];
  end

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return (a == GPIO_IN_ADDR) ? gpio_in : refmem[a];
  endfunction

  // Model: phase 0 idle, 1 awaiting grant, 2 copying (p = cycles since grant), 3 done.
  int          ph = 0, p = 0, m_k;
  logic [15:0] m_src = '0, m_dst = '0, m_len = '0, m_a;

  always @(posedge clk or posedge rst) begin
    if (rst) ph = 0;
    else begin
      case (ph)
        0: if (start) begin
          m_src = src; m_dst = dst; m_len = len;
          ph = (len == 16'd0) ? 3 : 1;
        end
        1: if (gnt_drv) begin ph = 2; p = 0; end
        2: begin
          if (p % 3 == 2) begin
            m_k = p / 3;
            m_a = m_dst + 16'(m_k);
            if (m_a == GPIO_OUT_ADDR) ref_gpio_out = ref_rd(m_src + 16'(m_k));
            else                      refmem[m_a]  = ref_rd(m_src + 16'(m_k));
            if (m_k == int'(m_len) - 1) ph = 3;
            else p++;
          end else p++;
        end
        3: ph = 0;
        default: ph = 0;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle_check();
    int          k, r;
    logic        e_we, e_req;
    logic [15:0] e_addr, e_wdata;
    k = p / 3;
    r = p % 3;
    e_req   = (ph == 1) || (ph == 2);
    e_we    = (ph == 2) && (r == 2);
    e_addr  = '0;
    e_wdata = '0;
    if (ph == 2 && r == 0) e_addr = m_src + 16'(k);
    if (e_we) begin
      e_addr  = m_dst + 16'(k);
      e_wdata = ref_rd(m_src + 16'(k));
    end
    check("cycle {busy,done,req,we,addr,wdata}",
          {44'd0, busy, done, bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_wdata},
          {44'd0, (ph != 0), (ph == 3), e_req, e_we, e_addr, e_wdata});
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
    mem[a]    = v;
    refmem[a] = v;
  endtask

  // Start in cycle 0; returns the cycle number of done and the bus_req-high cycle count.
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input int gnt_cyc, output int done_cyc, output int req_cyc);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    if (gnt_cyc > 0) gnt_drv = 1'b0;
    done_cyc = -1;
    req_cyc  = 0;
    for (int c = 1; c <= 3 * int'(l) + 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == gnt_cyc) gnt_drv = 1'b1;
      if (bif.bus_req) req_cyc++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    gnt_drv = 1'b1;
    if (done_cyc < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int dc, rc, w0, dseen;
    fork
      forever begin
        @(negedge clk);
        cycle_check();
      end
    join_none

    for (int i = 0; i < 65536; i++) begin
      mem[i]    = '0;
      refmem[i] = '0;
    end
    #1 rst = 1'b1;
    #2;
    check("reset outputs", {busy, done, bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_wdata}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic 3-word copy with grant tied high
    set_mem(16'h0, 16'h30); set_mem(16'h1, 16'h31); set_mem(16'h2, 16'h32);
    w0 = we_count;
    run_copy(16'h0, 16'h10, 16'd3, 0, dc, rc);
    check("t1 done cycle", dc, 11);
    check("t1 req cycles", rc, 10);
    check("t1 writes", we_count - w0, 3);
    check("t1 mem10", mem[16'h10], 16'h30);
    check("t1 mem11", mem[16'h11], 16'h31);
    check("t1 mem12", mem[16'h12], 16'h32);

    // Zero-length request
    set_mem(16'h5, 16'h55); set_mem(16'h6, 16'h66);
    w0 = we_count;
    run_copy(16'h5, 16'h6, 16'd0, 0, dc, rc);
    check("t2 done cycle", dc, 1);
    check("t2 req cycles", rc, 0);
    check("t2 writes", we_count - w0, 0);
    check("t2 mem6", mem[16'h6], 16'h66);

    // GPIO window in and out
    gpio_in = 16'h1A;
    run_copy(16'h2000, 16'h4, 16'd1, 0, dc, rc);
    check("t3 mem4", mem[16'h4], 16'h1A);
    run_copy(16'h4, 16'h2001, 16'd1, 0, dc, rc);
    check("t3 gpio_out", gpio_out, 16'h1A);

    // Grant withheld for five cycles
    set_mem(16'h30, 16'hB0); set_mem(16'h31, 16'hB1);
    run_copy(16'h30, 16'h38, 16'd2, 6, dc, rc);
    check("t4 done cycle", dc, 13);
    check("t4 req cycles", rc, 12);
    check("t4 mem38", mem[16'h38], 16'hB0);
    check("t4 mem39", mem[16'h39], 16'hB1);

    // Source address wraps past 16'hFFFF
    set_mem(16'hFFFF, 16'hC1); set_mem(16'h0, 16'hC0);
    run_copy(16'hFFFF, 16'h20, 16'd2, 0, dc, rc);
    check("t5 mem20", mem[16'h20], 16'hC1);
    check("t5 mem21", mem[16'h21], 16'hC0);

    // Overlapping forward copy propagates the first word
    set_mem(16'h60, 16'hD0); set_mem(16'h61, 16'hD1); set_mem(16'h62, 16'hD2);
    run_copy(16'h60, 16'h61, 16'd2, 0, dc, rc);
    check("t6 mem61", mem[16'h61], 16'hD0);
    check("t6 mem62", mem[16'h62], 16'hD0);

    // Reset during WAIT of word 1
    set_mem(16'h40, 16'hA0); set_mem(16'h41, 16'hA1); set_mem(16'h42, 16'hA2);
    set_mem(16'h50, 16'hEE); set_mem(16'h51, 16'hEE); set_mem(16'h52, 16'hEE);
    dseen = 0;
    @(negedge clk);
    src = 16'h40; dst = 16'h50; len = 16'd3; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dseen++;
    end
    #2 rst = 1'b1;
    #1;
    check("t7 outputs in reset", {busy, done, bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_wdata}, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    check("t7 no done", dseen, 0);
    check("t7 mem50", mem[16'h50], 16'hA0);
    check("t7 mem51", mem[16'h51], 16'hEE);
    check("t7 mem52", mem[16'h52], 16'hEE);
    run_copy(16'h40, 16'h50, 16'd3, 0, dc, rc);
    check("t7 restart done cycle", dc, 11);
    check("t7 restart mem51", mem[16'h51], 16'hA1);
    check("t7 restart mem52", mem[16'h52], 16'hA2);

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
